// File: rtl/mem_load_store_master.sv
// Data-port initiator: turns byte-addressed load/store requests into word-addressed
// memory strobes with lane enables, and returns one extended/flagged response per request.
module mem_load_store_master #(
  parameter int DATA_BITS = 16,
  parameter int TIMEOUT   = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [DATA_BITS-1:0] req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic [DATA_BITS-3:0] mem_addr,
  output logic                 mem_ren,
  output logic                 mem_wen,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_bsv,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready
);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT_LOW, RD_WAIT_DATA, WR_ISSUE, RESP
  } state_t;

  localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  lane_p0;
  logic [1:0]  size_p0;
  logic        uns_p0;
  logic [4:0]  wait_cnt;

  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
    return (size == 2'b11) || (size == 2'b01 && lane[0]) || (size == 2'b10 && lane != 2'b00);
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] lane,
                                               input logic uns, input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

  // Gating on mem_ready lets a read still in flight after reset drain first.
  assign req_ready = (state == IDLE) && mem_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      mem_ren    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_bsv    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && mem_ready) begin
            lane_p0  <= req_addr[1:0];
            size_p0  <= req_size;
            uns_p0   <= req_unsigned;
            mem_addr <= req_addr[DATA_BITS-1:2];
            if (access_err(req_size, req_addr[1:0])) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we) begin
              state     <= WR_ISSUE;
              mem_wen   <= 1'b1;
              mem_bsv   <= lane_mask(req_size, req_addr[1:0]);
              mem_wdata <= lane_replicate(req_size, req_wdata);
            end else begin
              state   <= RD_ISSUE;
              mem_ren <= 1'b1;
              mem_bsv <= lane_mask(req_size, req_addr[1:0]);
            end
          end
        end
        RD_ISSUE: begin
          mem_ren  <= 1'b0;
          mem_bsv  <= '0;
          wait_cnt <= '0;
          state    <= RD_WAIT_LOW;
        end
        // A ready still high from before the read is never taken as data.
        RD_WAIT_LOW: begin
          if (wait_cnt == WAIT_LAST) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 5'd1;
            if (!mem_ready) state <= RD_WAIT_DATA;
          end
        end
        RD_WAIT_DATA: begin
          if (mem_ready) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_extract(size_p0, lane_p0, uns_p0, mem_rdata);
          end else if (wait_cnt == WAIT_LAST) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 5'd1;
          end
        end
        WR_ISSUE: begin
          mem_wen    <= 1'b0;
          mem_bsv    <= '0;
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_store_master.sv
// Bench for mem_load_store_master: stub memory with selectable misbehaviour and a
// byte-array reference model; directed plan followed by randomized traffic.
module tb_mem_load_store_master;

  localparam int DATA_BITS = 8;
  localparam int TIMEOUT   = 31;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic                 req_we = 1'b0;
  logic [1:0]           req_size = 2'b00;
  logic                 req_unsigned = 1'b0;
  logic [DATA_BITS-1:0] req_addr = '0;
  logic [31:0]          req_wdata = '0;
  logic                 resp_valid;
  logic [31:0]          resp_rdata;
  logic                 resp_err;
  logic [DATA_BITS-3:0] mem_addr;
  logic                 mem_ren;
  logic                 mem_wen;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_bsv;
  logic [31:0]          mem_rdata = '0;
  logic                 mem_ready = 1'b1;

  mem_load_store_master #(.DATA_BITS(DATA_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_bsv(mem_bsv), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Stub memory. mode 0: 7-cycle read; 1: ready never drops; 2: ready never returns; 3: force ready.
  logic [31:0]          smem [0:63] = '{default: 32'h0};
  logic [DATA_BITS-3:0] rd_addr = '0;
  int                   mode = 0;
  int                   rem = 0;

  always @(posedge clk) begin
    if (mem_wen)
      for (int k = 0; k < 4; k++)
        if (mem_bsv[k]) smem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
    if (mode == 1 || mode == 3) begin
      mem_ready <= 1'b1;
      rem       <= 0;
    end else if (mem_ren) begin
      mem_ready <= 1'b0;
      rem       <= 7;
      rd_addr   <= mem_addr;
    end else if (rem > 0) begin
      rem <= rem - 1;
      if (rem == 1 && mode == 0) begin
        mem_ready <= 1'b1;
        mem_rdata <= smem[rd_addr];
      end
    end
  end

  logic [7:0] ref_mem [0:255] = '{default: 8'h0};
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [7:0] addr, input logic [31:0] wdata, input int tmo);
    int          n, lat, ren_n, wen_n, waited;
    logic        err, exp_err, bad_proto;
    logic [31:0] exp_rdata, got_rdata, got_wdata, exp_wdata, mask;
    logic [3:0]  got_bsv, exp_bsv;
    logic [5:0]  got_addr;
    logic        got_err;
    int          exp_lat;

    n = 1 << size;
    err = (size == 2'd3) || (int'(addr) % n != 0);
    exp_rdata = '0;
    exp_err = err;
    if (err)         exp_lat = 1;
    else if (we)     exp_lat = 2;
    else if (tmo != 0) begin exp_lat = TIMEOUT + 2; exp_err = 1'b1; end
    else begin
      exp_lat = 10;
      for (int i = 0; i < n; i++) exp_rdata |= 32'(ref_mem[int'(addr) + i]) << (8 * i);
      if (n < 4) begin
        mask = (32'h1 << (8 * n)) - 32'h1;
        if (!uns && exp_rdata[8*n-1]) exp_rdata |= ~mask;
      end
    end
    exp_bsv = '0;
    exp_wdata = '0;
    if (!err) begin
      for (int i = 0; i < n; i++) exp_bsv[int'(addr[1:0]) + i] = 1'b1;
      for (int k = 0; k < 4; k++) exp_wdata[8*k +: 8] = wdata[8*(k % n) +: 8];
    end

    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check({tag, "_ready_wait"}, 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;

    lat = 0; ren_n = 0; wen_n = 0; bad_proto = 1'b0;
    got_rdata = '0; got_err = 1'b0; got_bsv = '0; got_wdata = '0; got_addr = '0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (k == 1) req_valid = 1'b0;
      if (mem_ren && mem_wen) bad_proto = 1'b1;
      if (!mem_ren && !mem_wen && mem_bsv != 4'b0) bad_proto = 1'b1;
      if (mem_ren || mem_wen) begin
        got_bsv = mem_bsv;
        got_addr = mem_addr;
      end
      if (mem_ren) ren_n++;
      if (mem_wen) begin
        wen_n++;
        got_wdata = mem_wdata;
      end
      if (resp_valid) begin
        lat = k;
        got_rdata = resp_rdata;
        got_err = resp_err;
        break;
      end
    end

    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(got_err), 32'(exp_err));
    check({tag, "_rdata"}, got_rdata, exp_rdata);
    check({tag, "_ren"}, 32'(ren_n), (!err && !we) ? 32'd1 : 32'd0);
    check({tag, "_wen"}, 32'(wen_n), (!err && we) ? 32'd1 : 32'd0);
    check({tag, "_proto"}, 32'(bad_proto), 32'd0);
    if (!err) begin
      check({tag, "_bsv"}, 32'(got_bsv), 32'(exp_bsv));
      check({tag, "_maddr"}, 32'(got_addr), 32'(addr >> 2));
    end
    if (!err && we) check({tag, "_wdata"}, got_wdata, exp_wdata);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(resp_valid), 32'd0);

    if (!err && we)
      for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
  endtask

  initial begin
    int          r, waited;
    logic        rr_bad, rv_seen;
    logic [1:0]  sz;
    logic [7:0]  a;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ren", 32'(mem_ren), 32'd0);
    check("rst_wen", 32'(mem_wen), 32'd0);
    check("rst_bsv", 32'(mem_bsv), 32'd0);
    check("rst_maddr", 32'(mem_addr), 32'd0);
    check("rst_mwdata", mem_wdata, 32'd0);
    check("rst_resp", {29'd0, resp_valid, resp_err, |resp_rdata}, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    run_op("st_w40", 1'b1, 2'd2, 1'b0, 8'h40, 32'hDEADBEEF, 0);
    run_op("ld_w40", 1'b0, 2'd2, 1'b0, 8'h40, 32'h0, 0);
    run_op("st_b43", 1'b1, 2'd0, 1'b0, 8'h43, 32'h00000080, 0);
    run_op("ld_sb43", 1'b0, 2'd0, 1'b0, 8'h43, 32'h0, 0);
    run_op("ld_ub43", 1'b0, 2'd0, 1'b1, 8'h43, 32'h0, 0);
    run_op("st_h46", 1'b1, 2'd1, 1'b0, 8'h46, 32'h00008001, 0);
    run_op("ld_sh46", 1'b0, 2'd1, 1'b0, 8'h46, 32'h0, 0);
    run_op("err_w41", 1'b0, 2'd2, 1'b0, 8'h41, 32'h0, 0);
    run_op("err_h45", 1'b0, 2'd1, 1'b0, 8'h45, 32'h0, 0);
    run_op("err_sz3", 1'b1, 2'd3, 1'b0, 8'h40, 32'h12345678, 0);

    mode = 1;
    run_op("tmo_nodrop", 1'b0, 2'd2, 1'b0, 8'h40, 32'h0, 1);
    mode = 2;
    run_op("tmo_norise", 1'b0, 2'd2, 1'b0, 8'h40, 32'h0, 2);
    @(negedge clk);
    mode = 3;
    @(negedge clk);
    mode = 0;

    // Reset during RD_WAIT_DATA, then drain and reload.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 8'h44;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_strobes", {29'd0, mem_ren, mem_wen, |mem_bsv}, 32'd0);
    check("mid_rst_maddr", 32'(mem_addr), 32'd0);
    check("mid_rst_resp", {29'd0, resp_valid, resp_err, |resp_rdata}, 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    rr_bad = 1'b0; rv_seen = 1'b0; waited = 0;
    while (!mem_ready && waited < 20) begin
      if (req_ready) rr_bad = 1'b1;
      if (resp_valid) rv_seen = 1'b1;
      @(negedge clk);
      waited++;
    end
    check("drain_req_ready_low", 32'(rr_bad), 32'd0);
    check("drain_no_resp", 32'(rv_seen), 32'd0);
    check("drain_req_ready_up", 32'(req_ready), 32'd1);
    run_op("ld_after_rst", 1'b0, 2'd2, 1'b0, 8'h44, 32'h0, 0);
    run_op("ld_after_rst2", 1'b0, 2'd2, 1'b0, 8'h40, 32'h0, 0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a = 8'($urandom_range(0, 63));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~8'((1 << sz) - 1);
      run_op("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
